wavetable_voice_sched: RTL and testbench

Multi-voice wavetable scheduler that owns the single port of the 512x16 wavetable RAM and shares it between a host loader and a per-sample voice sweep. On each audio sample tick it advances one phase accumulator per voice and reads one wavetable sample per voice (two with interpolation). It sums the voices into one mixed sample and presents that sample to the output stage. It sits between the host/config bus and the wavetable RAM, upstream of the DAC/PWM output.

---
 rtl/wavetable_voice_sched.sv | 184 ++++++++++++++++++
 tb/tb_wavetable_voice_sched.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wavetable_voice_sched.sv
// wavetable_voice_sched
//   Owns the single port of the 512x16 wavetable RAM. Between audio ticks the
//   host may write the RAM. On each tick every voice gets a fixed-length slot:
//   its RAM sample is read, its contribution is added to a signed accumulator,
//   and its phase is advanced. After the last slot the mixed sample is
//   presented for one cycle.
//
//   Optional feature macro: WT_INTERP_EN. When it is defined, each slot does a
//   second read at address+1 and interpolates linearly using the 8 phase bits
//   below the address.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   sample_tick                  one-cycle audio-rate pulse
//   cfg_we/voice/inc/en          per-voice increment + enable write (any state)
//   host_wr_req/addr/data/ack    host RAM write; req held until the ack pulse
//   ram_addr/wdata/rdata         RAM port (rdata valid the cycle after ram_re)
//   ram_ce/we/re                 RAM strobes
//   mix_out, mix_valid           signed mixed sample + one-cycle strobe
//   tick_overrun                 sticky: a tick arrived with one already pending
module wavetable_voice_sched #(
  parameter int NUM_VOICES = 4,
  parameter int PHASE_W    = 24
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sample_tick,
  input  logic                          cfg_we,
  input  logic [$clog2(NUM_VOICES)-1:0] cfg_voice,
  input  logic [PHASE_W-1:0]            cfg_inc,
  input  logic                          cfg_en,
  input  logic                          host_wr_req,
  input  logic [8:0]                    host_wr_addr,
  input  logic [15:0]                   host_wr_data,
  output logic                          host_wr_ack,
  output logic [8:0]                    ram_addr,
  output logic [15:0]                   ram_wdata,
  input  logic [15:0]                   ram_rdata,
  output logic                          ram_ce,
  output logic                          ram_we,
  output logic                          ram_re,
  output logic [15:0]                   mix_out,
  output logic                          mix_valid,
  output logic                          tick_overrun
);
  localparam int VW = $clog2(NUM_VOICES);
  localparam int AW = 16 + VW;

`ifdef WT_INTERP_EN
  typedef enum logic [2:0] {IDLE, HWR, V_ADDR, V_DATA, V_ADDR2, V_DATA2, DONE} state_t;
  localparam state_t ADV = V_DATA2;  // slot's last state: accumulate + advance
`else
  typedef enum logic [2:0] {IDLE, HWR, V_ADDR, V_DATA, DONE} state_t;
  localparam state_t ADV = V_DATA;
`endif

  state_t               state, state_n;
  logic [VW-1:0]        voice;
  logic signed [AW-1:0] acc, contrib, acc_sum, mix_sh;
  logic [PHASE_W-1:0]   phase [NUM_VOICES];
  logic [PHASE_W-1:0]   inc   [NUM_VOICES];
  logic [NUM_VOICES-1:0] en;
  logic                 pending, overrun, tick_go, last;
  logic [8:0]           addr0;
  logic signed [15:0]   s_rd;

  assign addr0    = phase[voice][PHASE_W-1 -: 9];
  assign s_rd     = {~ram_rdata[15], ram_rdata[14:0]};  // offset-binary -> signed
  assign last     = (voice == VW'(NUM_VOICES - 1));
  assign tick_go  = sample_tick | pending;
  assign acc_sum  = acc + contrib;
  assign mix_sh   = acc_sum >>> VW;
  // The dropped tick is flagged in its own cycle; the register keeps it sticky.
  assign tick_overrun = overrun | (sample_tick & pending & (state != IDLE));

`ifdef WT_INTERP_EN
  logic signed [15:0] s0_q;
  logic [7:0]         frac;
  logic signed [16:0] diff;
  logic signed [25:0] prod, interp_v;

  assign frac     = phase[voice][PHASE_W-10 -: 8];
  assign diff     = {s_rd[15], s_rd} - {s0_q[15], s0_q};
  assign prod     = diff * $signed({1'b0, frac});
  assign interp_v = $signed({{10{s0_q[15]}}, s0_q}) + (prod >>> 8);
  assign contrib  = en[voice] ? interp_v[AW-1:0] : '0;
`else
  assign contrib  = en[voice] ? {{VW{s_rd[15]}}, s_rd} : '0;
`endif

  always_comb begin
    state_n     = state;
    ram_ce      = 1'b0;
    ram_we      = 1'b0;
    ram_re      = 1'b0;
    ram_addr    = '0;
    ram_wdata   = '0;
    host_wr_ack = 1'b0;
    mix_valid   = 1'b0;
    case (state)
      IDLE: begin
        if (tick_go)          state_n = V_ADDR;  // sweep beats host
        else if (host_wr_req) state_n = HWR;
      end
      HWR: begin
        ram_ce      = 1'b1;
        ram_we      = 1'b1;
        ram_addr    = host_wr_addr;
        ram_wdata   = host_wr_data;
        host_wr_ack = 1'b1;
        state_n     = IDLE;
      end
      V_ADDR: begin
        ram_ce   = 1'b1;
        ram_re   = 1'b1;
        ram_addr = addr0;
        state_n  = V_DATA;
      end
`ifdef WT_INTERP_EN
      V_DATA:  state_n = V_ADDR2;
      V_ADDR2: begin
        ram_ce   = 1'b1;
        ram_re   = 1'b1;
        ram_addr = addr0 + 9'd1;  // 511 wraps to 0
        state_n  = V_DATA2;
      end
      V_DATA2: state_n = last ? DONE : V_ADDR;
`else
      V_DATA:  state_n = last ? DONE : V_ADDR;
`endif
      DONE: begin
        mix_valid = 1'b1;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      voice   <= '0;
      acc     <= '0;
      pending <= 1'b0;
      overrun <= 1'b0;
      mix_out <= '0;
      en      <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        phase[i] <= '0;
        inc[i]   <= '0;
      end
`ifdef WT_INTERP_EN
      s0_q    <= '0;
`endif
    end else begin
      state <= state_n;
      // Same-cycle cfg write to the voice being advanced: the advance below
      // reads the old inc/en, the new values apply from its next slot.
      if (cfg_we) begin
        inc[cfg_voice] <= cfg_inc;
        en[cfg_voice]  <= cfg_en;
      end
      if (state == IDLE) pending <= 1'b0;
      else if (sample_tick) begin
        if (pending) overrun <= 1'b1;
        else         pending <= 1'b1;
      end
      if (state == IDLE && tick_go) begin
        voice <= '0;
        acc   <= '0;
      end
`ifdef WT_INTERP_EN
      if (state == V_DATA) s0_q <= s_rd;
`endif
      if (state == ADV) begin
        acc          <= acc_sum;
        phase[voice] <= en[voice] ? phase[voice] + inc[voice] : '0;
        voice        <= voice + 1'b1;
        // Load the mix on the way into DONE so it lines up with mix_valid.
        if (last) mix_out <= mix_sh[15:0];
      end
    end
  end
endmodule

// File: tb/tb_wavetable_voice_sched.sv
module tb_wavetable_voice_sched;
  localparam int NV = 4;
  localparam int PW = 24;
  localparam int SH = 2;
`ifdef WT_INTERP_EN
  localparam int CPV = 4;
  localparam bit INTERP = 1'b1;
`else
  localparam int CPV = 2;
  localparam bit INTERP = 1'b0;
`endif
  localparam int SWEEP = CPV * NV + 1;
  localparam logic [23:0] INC_A  = INTERP ? 24'h004000 : 24'h008000;
  localparam logic [15:0] EXP_A2 = INTERP ? 16'h0600 : 16'h0800;
  localparam logic [23:0] WRAP1  = INTERP ? 24'hFFC000 : 24'hFF8000;

  logic clk, rst, sample_tick, cfg_we, cfg_en, host_wr_req, host_wr_ack;
  logic [1:0]  cfg_voice;
  logic [23:0] cfg_inc;
  logic [8:0]  host_wr_addr, ram_addr;
  logic [15:0] host_wr_data, ram_wdata, ram_rdata, mix_out;
  logic ram_ce, ram_we, ram_re, mix_valid, tick_overrun, mem_clr;

  wavetable_voice_sched #(.NUM_VOICES(NV), .PHASE_W(PW)) dut (
    .clk(clk), .rst(rst), .sample_tick(sample_tick),
    .cfg_we(cfg_we), .cfg_voice(cfg_voice), .cfg_inc(cfg_inc), .cfg_en(cfg_en),
    .host_wr_req(host_wr_req), .host_wr_addr(host_wr_addr),
    .host_wr_data(host_wr_data), .host_wr_ack(host_wr_ack),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_re(ram_re),
    .mix_out(mix_out), .mix_valid(mix_valid), .tick_overrun(tick_overrun)
  );

  // Wavetable RAM: one port, registered read.
  logic [15:0] mem [512];
  always @(posedge clk) begin
    if (mem_clr) for (int i = 0; i < 512; i++) mem[i] <= '0;
    else begin
      if (ram_ce && ram_we) mem[ram_addr] <= ram_wdata;
      if (ram_ce && ram_re) ram_rdata <= mem[ram_addr];
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, fails = 0, mv_count = 0;
  logic [15:0] exp_q[$];

  // Reference model state
  logic [15:0] ref_mem [512];
  int ref_phase [NV];
  int ref_inc [NV];
  bit ref_en [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every mix_valid pops the oldest expected sample.
  always @(negedge clk) begin
    if (mix_valid === 1'b1) begin
      mv_count++;
      if (exp_q.size() == 0) chk("mix_unexpected", {31'b0, mix_valid}, 32'd0);
      else chk("mix_out", {16'b0, mix_out}, {16'b0, exp_q.pop_front()});
    end
  end

  // One sweep from the spec's arithmetic: nearest (or interpolated) sample
  // per enabled voice, summed, divided by the voice count.
  function automatic logic [15:0] model_sweep();
    int acc = 0;
    for (int v = 0; v < NV; v++) begin
      if (ref_en[v]) begin
        int a, s0, s1, fr;
        logic [15:0] w;
        a = ref_phase[v] >> (PW - 9);
        w = ref_mem[a] ^ 16'h8000;
        s0 = int'($signed(w));
        if (INTERP) begin
          w = ref_mem[(a + 1) % 512] ^ 16'h8000;
          s1 = int'($signed(w));
          fr = (ref_phase[v] >> (PW - 17)) & 255;
          acc += s0 + (((s1 - s0) * fr) >>> 8);
        end else acc += s0;
        ref_phase[v] = (ref_phase[v] + ref_inc[v]) & 32'hFFFFFF;
      end else ref_phase[v] = 0;
    end
    acc = acc >>> SH;
    return acc[15:0];
  endfunction

  task automatic ref_reset();
    for (int v = 0; v < NV; v++) begin
      ref_phase[v] = 0; ref_inc[v] = 0; ref_en[v] = 1'b0;
    end
  endtask

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ram_ce"}, {31'b0, ram_ce}, 0);
    chk({tag, "_ram_we"}, {31'b0, ram_we}, 0);
    chk({tag, "_ram_re"}, {31'b0, ram_re}, 0);
    chk({tag, "_ram_addr"}, {23'b0, ram_addr}, 0);
    chk({tag, "_ram_wdata"}, {16'b0, ram_wdata}, 0);
    chk({tag, "_mix_out"}, {16'b0, mix_out}, 0);
    chk({tag, "_mix_valid"}, {31'b0, mix_valid}, 0);
    chk({tag, "_ack"}, {31'b0, host_wr_ack}, 0);
    chk({tag, "_overrun"}, {31'b0, tick_overrun}, 0);
  endtask

  task automatic do_cfg(input int v, input logic [23:0] inc, input bit en);
    cfg_we = 1'b1; cfg_voice = 2'(v); cfg_inc = inc; cfg_en = en;
    next();
    cfg_we = 1'b0;
    ref_inc[v] = int'(inc); ref_en[v] = en;
  endtask

  task automatic host_write(input logic [8:0] a, input logic [15:0] d);
    int c;
    int lat = -1;
    host_wr_req = 1'b1; host_wr_addr = a; host_wr_data = d; c = cyc;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (host_wr_ack) begin lat = cyc - c; break; end
    end
    chk("host_ack_lat", lat, 1);
    next();
    host_wr_req = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic do_tick(input logic [15:0] e);
    int t0, base;
    int lat = -1;
    base = mv_count;
    exp_q.push_back(e);
    sample_tick = 1'b1; t0 = cyc;
    next();
    sample_tick = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk); #1;
      if (mv_count > base) begin lat = cyc - t0; break; end
    end
    chk("sweep_lat", lat, SWEEP);
    next();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int base, t0, bad, lat;
    logic [15:0] e1, e2;
    rst = 1'b1; mem_clr = 1'b1; sample_tick = 1'b0; cfg_we = 1'b0;
    cfg_voice = '0; cfg_inc = '0; cfg_en = 1'b0;
    host_wr_req = 1'b0; host_wr_addr = '0; host_wr_data = '0;
    for (int i = 0; i < 512; i++) ref_mem[i] = '0;
    ref_reset();
    repeat (3) next();
    rst = 1'b0; mem_clr = 1'b0;
    @(negedge clk);
    chk_zero("reset");
    next();

    // Preload and two nearest/interpolated ticks on voice 0
    host_write(9'd0, 16'h9000);
    host_write(9'd1, 16'hA000);
    do_cfg(0, INC_A, 1'b1);
    void'(model_sweep());
    do_tick(16'h0400);
    void'(model_sweep());
    do_tick(EXP_A2);

    // Address wrap: zero the phase, jump to the top of the table, step over 511
    host_write(9'd511, 16'h7FFF);
    do_cfg(0, 24'h0, 1'b0);
    do_tick(model_sweep());
    do_cfg(0, WRAP1, 1'b1);
    do_tick(model_sweep());
    do_cfg(0, INC_A, 1'b1);
    do_tick(model_sweep());
    do_tick(model_sweep());

    // Arbitration: host request and tick in the same IDLE cycle
    bad = 0; lat = -1; base = mv_count;
    exp_q.push_back(model_sweep());
    host_wr_req = 1'b1; host_wr_addr = 9'd5; host_wr_data = 16'h1234;
    sample_tick = 1'b1; t0 = cyc;
    next();
    sample_tick = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (ram_we && !host_wr_ack) bad++;
      if (host_wr_ack) begin lat = cyc - t0; break; end
    end
    chk("arb_ack_lat", lat, SWEEP + 2);
    chk("arb_we_in_sweep", bad, 0);
    chk("arb_sweep_first", mv_count - base, 1);
    next();
    host_wr_req = 1'b0;
    ref_mem[5] = 16'h1234;

    // Overrun: ticks at 0, 3, 5 -> two back-to-back sweeps, third tick dropped
    do_cfg(1, 24'h123456, 1'b1);
    base = mv_count;
    e1 = model_sweep(); e2 = model_sweep();
    exp_q.push_back(e1); exp_q.push_back(e2);
    for (int k = 0; k < 45; k++) begin
      sample_tick = (k == 0 || k == 3 || k == 5);
      @(negedge clk);
      if (k == 4) chk("ovr_before", {31'b0, tick_overrun}, 0);
      if (k == 5) chk("ovr_at5", {31'b0, tick_overrun}, 1);
      next();
    end
    sample_tick = 1'b0;
    chk("ovr_mix_count", mv_count - base, 2);
    chk("ovr_sticky", {31'b0, tick_overrun}, 1);

    // Reset in the middle of a sweep
    base = mv_count;
    for (int k = 0; k < 25; k++) begin
      sample_tick = (k == 0);
      rst = (k == 4 || k == 5);
      @(negedge clk);
      if (k == 5) chk_zero("midrst");
      next();
    end
    rst = 1'b0;
    chk("midrst_no_mix", mv_count - base, 0);
    ref_reset();
    do_tick(16'h0000);

    // Randomized: fill the table, then random voice configs per tick
    for (int a = 0; a < 512; a++) host_write(9'(a), 16'($urandom));
    for (int it = 0; it < 25; it++) begin
      for (int v = 0; v < NV; v++)
        if ($urandom_range(0, 2) != 0) do_cfg(v, 24'($urandom), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) host_write(9'($urandom), 16'($urandom));
      do_tick(model_sweep());
    end

    repeat (4) next();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
